// File: rtl/fix_tx_scheduler_if.sv
// Source-side and header-encoder-side signals of the FIX tx scheduler.
// The master modport is the scheduler; the slave modport is the environment.
interface fix_tx_scheduler_if #(
    parameter int FIX_PAYLOAD_LEN = 512,
    parameter int SEQ_W           = 32
);
    logic [5:0]                   src_req;
    logic [6*FIX_PAYLOAD_LEN-1:0] src_payload;
    logic [5:0]                   src_grant;
    logic [FIX_PAYLOAD_LEN-1:0]   hdr_payload;
    logic                         hdr_valid;
    logic [SEQ_W-1:0]             hdr_seq_num;
    logic                         hdr_encoded;

    modport master (
        input  src_req, src_payload, hdr_encoded,
        output src_grant, hdr_payload, hdr_valid, hdr_seq_num
    );

    modport slave (
        output src_req, src_payload, hdr_encoded,
        input  src_grant, hdr_payload, hdr_valid, hdr_seq_num
    );
endinterface

// File: rtl/fix_tx_scheduler.sv
// Serialises six FIX tx encoders onto one header encoder, owns MsgSeqNum and the heartbeat timer.
// Optional order throttle: define FIX_TX_ORDER_THROTTLE_EN.
module fix_tx_scheduler #(
    parameter int FIX_PAYLOAD_LEN = 512,
    parameter int SEQ_W           = 32,
    parameter int HB_CYCLES       = 1000,
    parameter int ENC_TIMEOUT     = 64,
    parameter int THR_CYCLES      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 session_up,
    fix_tx_scheduler_if.master   bus,
    output logic                 hb_req,
    output logic                 enc_timeout,
    output logic                 busy
);
    localparam int SRC_N      = 6;
    localparam int SRC_RESEND = 2;
    localparam int SRC_HB     = 4;
    localparam int SRC_ORDER  = 5;
    localparam int HB_W       = $clog2(HB_CYCLES);
    localparam int TO_W       = $clog2(ENC_TIMEOUT);
    localparam logic [SRC_N-1:0] SESSION_SRCS = 6'b001001;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_ENC, DONE} state_e;

    state_e                     state_q, state_d;
    logic [2:0]                 winner_q, winner_d;
    logic [SRC_N-1:0]           grant_q, grant_d;
    logic [FIX_PAYLOAD_LEN-1:0] payload_q, payload_d;
    logic                       valid_q, valid_d;
    logic [SEQ_W-1:0]           seq_q, seq_d;
    logic [TO_W-1:0]            to_cnt_q, to_cnt_d;
    logic [HB_W-1:0]            hb_cnt_q, hb_cnt_d;
    logic                       hb_req_q, hb_req_d;
    logic                       enc_to_q, enc_to_d;
    logic [SRC_N-1:0]           eligible;
    logic [2:0]                 pick;
    logic                       any_eligible;
    logic                       order_ok;

`ifdef FIX_TX_ORDER_THROTTLE_EN
    localparam int THR_W = $clog2(THR_CYCLES + 1);
    logic [THR_W-1:0] thr_cnt_q, thr_cnt_d;

    // Saturating count of cycles since the last order grant.
    assign order_ok = (thr_cnt_q == THR_W'(THR_CYCLES));

    always_comb begin
        thr_cnt_d = thr_cnt_q;
        if (state_q == LOAD && winner_q == 3'(SRC_ORDER)) begin
            thr_cnt_d = '0;
        end else if (!order_ok) begin
            thr_cnt_d = thr_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) thr_cnt_q <= '0;
        else     thr_cnt_q <= thr_cnt_d;
    end
`else
    assign order_ok = 1'b1;
`endif

    always_comb begin
        eligible = bus.src_req & (session_up ? {SRC_N{1'b1}} : SESSION_SRCS);
        eligible[SRC_ORDER] = eligible[SRC_ORDER] & order_ok;
        pick = '0;
        for (int i = SRC_N - 1; i >= 0; i--) begin
            if (eligible[i]) pick = 3'(i);
        end
    end

    assign any_eligible = |eligible;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d   = state_q;
        winner_d  = winner_q;
        grant_d   = '0;
        payload_d = payload_q;
        valid_d   = valid_q;
        seq_d     = seq_q;
        to_cnt_d  = to_cnt_q;
        enc_to_d  = 1'b0;
        hb_cnt_d  = hb_cnt_q;
        hb_req_d  = hb_req_q;

        unique case (state_q)
            IDLE: begin
                if (any_eligible) begin
                    winner_d = pick;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                payload_d = bus.src_payload[winner_q*FIX_PAYLOAD_LEN +: FIX_PAYLOAD_LEN];
                grant_d   = SRC_N'(1) << winner_q;
                valid_d   = 1'b1;
                to_cnt_d  = '0;
                state_d   = WAIT_ENC;
            end
            WAIT_ENC: begin
                if (bus.hdr_encoded) begin
                    valid_d = 1'b0;
                    state_d = DONE;
                end else if (to_cnt_q == TO_W'(ENC_TIMEOUT - 1)) begin
                    valid_d  = 1'b0;
                    enc_to_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            DONE: begin
                // A resend replays the current number; zero is never a legal MsgSeqNum.
                if (winner_q != 3'(SRC_RESEND)) begin
                    seq_d = (seq_q == {SEQ_W{1'b1}}) ? SEQ_W'(1) : seq_q + 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (!session_up || state_q == LOAD) begin
            hb_cnt_d = '0;
        end else if (state_q == IDLE && !any_eligible && hb_cnt_q != HB_W'(HB_CYCLES - 1)) begin
            hb_cnt_d = hb_cnt_q + 1'b1;
        end

        if (session_up && state_q == IDLE && hb_cnt_q == HB_W'(HB_CYCLES - 1)) begin
            hb_req_d = 1'b1;
        end
        if (state_q == LOAD && winner_q == 3'(SRC_HB)) begin
            hb_req_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q   <= IDLE;
            winner_q  <= '0;
            grant_q   <= '0;
            payload_q <= '0;
            valid_q   <= 1'b0;
            seq_q     <= SEQ_W'(1);
            to_cnt_q  <= '0;
            hb_cnt_q  <= '0;
            hb_req_q  <= 1'b0;
            enc_to_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            winner_q  <= winner_d;
            grant_q   <= grant_d;
            payload_q <= payload_d;
            valid_q   <= valid_d;
            seq_q     <= seq_d;
            to_cnt_q  <= to_cnt_d;
            hb_cnt_q  <= hb_cnt_d;
            hb_req_q  <= hb_req_d;
            enc_to_q  <= enc_to_d;
        end
    end

    assign bus.src_grant   = grant_q;
    assign bus.hdr_payload = payload_q;
    assign bus.hdr_valid   = valid_q;
    assign bus.hdr_seq_num = seq_q;
    assign hb_req          = hb_req_q;
    assign enc_timeout     = enc_to_q;
    assign busy            = (state_q != IDLE);
endmodule
